// File: rtl/noc_checker_pkg.sv
// rtl/noc_checker_pkg.sv - shared error indices and framing FSM state type for the NoC flit checker
package noc_checker_pkg;

    // Bit positions inside err_bits / first_err
    localparam int ERR_LEN_OVER      = 0;
    localparam int ERR_VAL_DROP      = 1;
    localparam int ERR_DATA_UNSTABLE = 2;
    localparam int ERR_DST_MISMATCH  = 3;
    localparam int ERR_NUM           = 4;

    // Framing state: expecting a header flit, or inside a packet body
    typedef enum logic {
        HDR  = 1'b0,
        BODY = 1'b1
    } frame_state_t;

endpackage

// File: rtl/noc_stall_monitor.sv
// rtl/noc_stall_monitor.sv - flags valid drops and data changes while a flit is stalled
module noc_stall_monitor #(
    parameter int NOC_DATA_W = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mon_val,
    input  logic                  mon_rdy,
    input  logic [NOC_DATA_W-1:0] mon_data,
    output logic                  val_drop,
    output logic                  data_unstable
);

    logic                  r_stalled_q;
    logic [NOC_DATA_W-1:0] r_data_q;

    // Remember whether last cycle was a stall and what data was offered then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stalled_q <= 1'b0;
            r_data_q    <= '0;
        end else begin
            r_stalled_q <= mon_val & ~mon_rdy;
            r_data_q    <= mon_data;
        end
    end

    // Pulses only; the top registers them into sticky bits
    always_comb begin
        val_drop      = r_stalled_q & ~mon_val;
        data_unstable = r_stalled_q & mon_val & (mon_data != r_data_q);
    end

endmodule

// File: rtl/noc_flit_checker.sv
// rtl/noc_flit_checker.sv - passive framing, destination and stall-rule checker for one val/rdy NoC link
module noc_flit_checker
    import noc_checker_pkg::*;
#(
    parameter int NOC_DATA_W = 512,
    parameter int LEN_LSB    = 0,
    parameter int LEN_W      = 22,
    parameter int MAX_BODY   = 1024,
    parameter int CHECK_DST  = 1,
    parameter int DST_LSB    = 44,
    parameter int DST_W      = 16,
    parameter int EXP_DST    = 0,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mon_val,
    input  logic [NOC_DATA_W-1:0] mon_data,
    input  logic                  mon_rdy,
    input  logic                  clear,
    output logic                  err_any,
    output logic [3:0]            err_bits,
    output logic [3:0]            first_err,
    output logic                  in_pkt,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      flit_cnt
);

    if (64'(MAX_BODY) >= (64'd1 << LEN_W)) begin : g_bad_max_body
        $error("noc_flit_checker: MAX_BODY does not fit in LEN_W bits");
    end
    if (LEN_LSB + LEN_W > NOC_DATA_W) begin : g_bad_len_field
        $error("noc_flit_checker: length field exceeds flit width");
    end

    localparam logic [LEN_W-1:0] MAX_BODY_L = LEN_W'(MAX_BODY);
    localparam logic [DST_W-1:0] EXP_DST_L  = DST_W'(EXP_DST);

    frame_state_t          r_state, w_state_nxt;
    logic [LEN_W-1:0]      r_remaining;
    logic [ERR_NUM-1:0]    r_err_bits, r_first_err;
    logic [CNT_W-1:0]      r_pkt_cnt, r_flit_cnt;

    logic                  w_hs, w_hdr_hs, w_len_over, w_dst_bad, w_pkt_done;
    logic                  w_val_drop, w_data_unstable;
    logic [LEN_W-1:0]      w_len;
    logic [ERR_NUM-1:0]    w_err_set;

    noc_stall_monitor #(
        .NOC_DATA_W (NOC_DATA_W)
    ) u_stall (
        .clk           (clk),
        .rst_n         (rst_n),
        .mon_val       (mon_val),
        .mon_rdy       (mon_rdy),
        .mon_data      (mon_data),
        .val_drop      (w_val_drop),
        .data_unstable (w_data_unstable)
    );

    // Decode the current flit: handshake, header fields and error sources
    always_comb begin
        w_hs       = mon_val & mon_rdy;
        w_hdr_hs   = w_hs & (r_state == HDR);
        w_len      = mon_data[LEN_LSB +: LEN_W];
        w_len_over = w_hdr_hs & (w_len > MAX_BODY_L);
        w_dst_bad  = (CHECK_DST != 0) & w_hdr_hs & (mon_data[DST_LSB +: DST_W] != EXP_DST_L);
        w_pkt_done = (w_hdr_hs & (w_len == '0))
                   | (w_hs & (r_state == BODY) & (r_remaining == LEN_W'(1)));
        w_err_set                    = '0;
        w_err_set[ERR_LEN_OVER]      = w_len_over;
        w_err_set[ERR_VAL_DROP]      = w_val_drop;
        w_err_set[ERR_DATA_UNSTABLE] = w_data_unstable;
        w_err_set[ERR_DST_MISMATCH]  = w_dst_bad;
    end

    // Framing next state; an over-length header stays in HDR so the next flit resyncs as a header
    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            if (r_state == HDR) begin
                if ((w_len != '0) && !w_len_over) begin
                    w_state_nxt = BODY;
                end
            end else if (r_remaining == LEN_W'(1)) begin
                w_state_nxt = HDR;
            end
        end
    end

    // Framing state and body flits still expected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HDR;
            r_remaining <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hdr_hs) begin
                r_remaining <= w_len;
            end else if (w_hs) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // Sticky errors, first-error capture and saturating counters; clear wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_bits  <= '0;
            r_first_err <= '0;
            r_pkt_cnt   <= '0;
            r_flit_cnt  <= '0;
        end else if (clear) begin
            r_err_bits  <= '0;
            r_first_err <= '0;
            r_pkt_cnt   <= '0;
            r_flit_cnt  <= '0;
        end else begin
            r_err_bits <= r_err_bits | w_err_set;
            if ((r_first_err == '0) && (w_err_set != '0)) begin
                r_first_err <= w_err_set & (~w_err_set + ERR_NUM'(1));
            end
            if (w_pkt_done && !(&r_pkt_cnt)) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
            if (w_hs && !(&r_flit_cnt)) begin
                r_flit_cnt <= r_flit_cnt + CNT_W'(1);
            end
        end
    end

    assign err_bits  = r_err_bits;
    assign err_any   = |r_err_bits;
    assign first_err = r_first_err;
    assign in_pkt    = (r_state == BODY);
    assign pkt_cnt   = r_pkt_cnt;
    assign flit_cnt  = r_flit_cnt;

endmodule

// File: tb/tb_noc_flit_checker.sv
// tb/tb_noc_flit_checker.sv - directed self-checking bench for noc_flit_checker
module tb_noc_flit_checker;

    localparam int DW = 512;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mon_val;
    logic [DW-1:0] mon_data;
    logic          mon_rdy;
    logic          clear;
    logic          err_any;
    logic [3:0]    err_bits;
    logic [3:0]    first_err;
    logic          in_pkt;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] flit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    noc_flit_checker #(
        .NOC_DATA_W (DW),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mon_val   (mon_val),
        .mon_data  (mon_data),
        .mon_rdy   (mon_rdy),
        .clear     (clear),
        .err_any   (err_any),
        .err_bits  (err_bits),
        .first_err (first_err),
        .in_pkt    (in_pkt),
        .pkt_cnt   (pkt_cnt),
        .flit_cnt  (flit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr(input int len, input int dst);
        logic [DW-1:0] h;
        h         = '0;
        h[21:0]   = len[21:0];
        h[59:44]  = dst[15:0];
        return h;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [DW-1:0] d);
        mon_val  = v;
        mon_rdy  = r;
        mon_data = d;
        tick();
    endtask

    task automatic idle();
        mon_val = 1'b0;
        mon_rdy = 1'b1;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [DW-1:0] d_a;
    logic [DW-1:0] d_b;

    initial begin
        rst_n    = 1'b0;
        mon_val  = 1'b0;
        mon_rdy  = 1'b1;
        mon_data = '0;
        clear    = 1'b0;
        tick();
        tick();
        check("rst_err_bits", 32'(err_bits), 32'h0);
        check("rst_err_any", 32'(err_any), 32'h0);
        check("rst_first_err", 32'(first_err), 32'h0);
        check("rst_in_pkt", 32'(in_pkt), 32'h0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
        check("rst_flit_cnt", 32'(flit_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // Legal traffic: len 3 + 3 body flits, then len 0 header
        drive(1'b1, 1'b1, hdr(3, 0));
        check("legal_in_pkt_hdr", 32'(in_pkt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, {16{32'hdead_0000 + 32'(i)}});
        end
        check("legal_in_pkt_end", 32'(in_pkt), 32'h0);
        check("legal_pkt_mid", 32'(pkt_cnt), 32'h1);
        drive(1'b1, 1'b1, hdr(0, 0));
        idle();
        tick();
        check("legal_pkt_cnt", 32'(pkt_cnt), 32'h2);
        check("legal_flit_cnt", 32'(flit_cnt), 32'h5);
        check("legal_err_bits", 32'(err_bits), 32'h0);
        check("legal_in_pkt", 32'(in_pkt), 32'h0);
        do_clear();

        // Over-length header, then a legal zero-length header resyncs
        drive(1'b1, 1'b1, hdr(1025, 0));
        check("over_in_pkt", 32'(in_pkt), 32'h0);
        drive(1'b1, 1'b1, hdr(0, 0));
        idle();
        tick();
        check("over_err_bits", 32'(err_bits), 32'h1);
        check("over_first_err", 32'(first_err), 32'h1);
        check("over_err_any", 32'(err_any), 32'h1);
        check("over_pkt_cnt", 32'(pkt_cnt), 32'h1);
        check("over_flit_cnt", 32'(flit_cnt), 32'h2);
        do_clear();
        check("clear_err_bits", 32'(err_bits), 32'h0);

        // Valid dropped after a two-cycle stall
        d_a = hdr(0, 0);
        d_a[100] = 1'b1;
        drive(1'b1, 1'b0, d_a);
        drive(1'b1, 1'b0, d_a);
        check("vdrop_none_yet", 32'(err_bits), 32'h0);
        drive(1'b0, 1'b0, d_a);
        check("vdrop_err_bits", 32'(err_bits), 32'h2);
        check("vdrop_first_err", 32'(first_err), 32'h2);
        check("vdrop_flit_cnt", 32'(flit_cnt), 32'h0);
        do_clear();

        // Data changes on the second stalled cycle, then the flit is accepted
        d_b = hdr(0, 0);
        drive(1'b1, 1'b0, d_a);
        drive(1'b1, 1'b0, d_b);
        check("unstab_err_bits", 32'(err_bits), 32'h4);
        check("unstab_first_err", 32'(first_err), 32'h4);
        drive(1'b1, 1'b1, d_b);
        idle();
        tick();
        check("unstab_err_final", 32'(err_bits), 32'h4);
        check("unstab_pkt_cnt", 32'(pkt_cnt), 32'h1);
        do_clear();

        // Destination mismatch with normal framing
        drive(1'b1, 1'b1, hdr(2, 1));
        check("dst_in_pkt", 32'(in_pkt), 32'h1);
        drive(1'b1, 1'b1, '1);
        drive(1'b1, 1'b1, '0);
        idle();
        tick();
        check("dst_err_bits", 32'(err_bits), 32'h8);
        check("dst_first_err", 32'(first_err), 32'h8);
        check("dst_pkt_cnt", 32'(pkt_cnt), 32'h1);
        check("dst_flit_cnt", 32'(flit_cnt), 32'h3);
        check("dst_in_pkt_end", 32'(in_pkt), 32'h0);

        // Clear in the same cycle as an over-length header
        clear = 1'b1;
        drive(1'b1, 1'b1, hdr(1025, 0));
        clear = 1'b0;
        idle();
        check("clr_err_bits", 32'(err_bits), 32'h0);
        check("clr_first_err", 32'(first_err), 32'h0);
        check("clr_pkt_cnt", 32'(pkt_cnt), 32'h0);
        check("clr_flit_cnt", 32'(flit_cnt), 32'h0);

        // Reset in the middle of a body; next handshake must be a header
        drive(1'b1, 1'b1, hdr(5, 0));
        drive(1'b1, 1'b1, hdr(0, 0));
        check("rstbody_in_pkt", 32'(in_pkt), 32'h1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstbody_async", 32'(in_pkt), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b1, hdr(0, 0));
        idle();
        check("rstbody_pkt_cnt", 32'(pkt_cnt), 32'h1);
        check("rstbody_in_pkt2", 32'(in_pkt), 32'h0);
        do_clear();

        // Saturation: 20 header-only packets into 4-bit counters
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, hdr(0, 0));
        end
        idle();
        tick();
        check("sat_pkt_cnt", 32'(pkt_cnt), 32'hf);
        check("sat_flit_cnt", 32'(flit_cnt), 32'hf);
        check("sat_err_bits", 32'(err_bits), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_flit_checker.md
# noc_flit_checker

Passive, parametrised runtime checker for one val/rdy NoC link. It tracks header/body framing using the header length field and checks each header against configured limits and the expected destination. It also enforces the stall rules: valid held, data stable. Violations are recorded in sticky error bits, along with the first error code and saturating packet/flit counters. One instance sits on any NoC link (eth/ip/udp/tcp tiles) in simulation or on chip; it never drives the link.

## Interface
- NOC_DATA_W, 512, flit width; equals `NOC_DATA_WIDTH`
- LEN_LSB, 0, LSB of body-length field in header flit
- LEN_W, 22, width of body-length field (body flits following header)
- MAX_BODY, 1024, largest legal body length
- CHECK_DST, 1, 1 enables destination check
- DST_LSB, 44, LSB of {dst_x, dst_y} field in header
- DST_W, 16, width of {dst_x, dst_y}
- EXP_DST, 0, expected {dst_x, dst_y}
- CNT_W, 32, counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mon_val  in  1  observed link valid
- mon_data  in  NOC_DATA_W  observed link data
- mon_rdy  in  1  observed link ready
- clear  in  1  synchronous clear of errors and counters
- err_any  out  1  OR of err_bits
- err_bits  out  4  sticky: [0] LEN_OVER, [1] VAL_DROP, [2] DATA_UNSTABLE, [3] DST_MISMATCH
- first_err  out  4  one-hot code of first error since reset/clear; 0 if none
- in_pkt  out  1  FSM in BODY
- pkt_cnt  out  CNT_W  completed packets, saturating
- flit_cnt  out  CNT_W  handshaked flits, saturating

## Operation
- Handshake (hs) = mon_val & mon_rdy.
- FSM states:
  - HDR: on hs, capture len = mon_data[LEN_LSB +: LEN_W].
    - len == 0: pkt_cnt++, stay in HDR.
    - len > MAX_BODY: set LEN_OVER, stay in HDR. The next flit is treated as a header (resync); pkt_cnt unchanged.
    - Otherwise: remaining <= len, go to BODY.
  - BODY: on hs, remaining--. When remaining == 1 on hs: pkt_cnt++, go to HDR.
- DST check: only on header hs with CHECK_DST = 1. It compares mon_data[DST_LSB +: DST_W] to EXP_DST; a mismatch sets DST_MISMATCH, and framing continues normally.
- Stall tracking: stalled_q <= mon_val & ~mon_rdy, data_q <= mon_data.
  - stalled_q & ~mon_val sets VAL_DROP.
  - stalled_q & mon_val & (mon_data != data_q) sets DATA_UNSTABLE.
  - Both may set in different cycles of the same stall.
- flit_cnt increments on every hs.
- first_err: loads on the first cycle any error sets while first_err == 0. Simultaneous errors load lowest bit index only; err_bits gets all of them.
- clear: zeroes err_bits, first_err, pkt_cnt, flit_cnt. Clear has priority over same-cycle error sets and increments. FSM, remaining, and stall tracking are unaffected.
- Counters stop at all-ones.

## Timing
- All outputs registered; an error or count is visible the cycle after the causing edge.
- Reset values: all outputs 0. FSM resets to HDR, stalled_q = 0.
- Reset asserted mid-packet returns to HDR immediately (async). The first hs after release is a header.
- remaining is LEN_W bits; MAX_BODY must be < 2^LEN_W.
- No combinational path from inputs to outputs.
- Throughput: one flit per cycle, no back-pressure generated.

## Structure
- Package noc_checker_pkg holds:
  - Error bit index localparams (ERR_LEN_OVER = 0, ERR_VAL_DROP = 1, ERR_DATA_UNSTABLE = 2, ERR_DST_MISMATCH = 3).
  - The FSM state enum {HDR, BODY}.
- Sub-module noc_stall_monitor (params NOC_DATA_W): owns stalled_q/data_q and outputs val_drop/data_unstable pulses.
- Top holds FSM, counters, and sticky/first-error logic.
- Elaboration-time $error if MAX_BODY >= 2^LEN_W or LEN_LSB + LEN_W > NOC_DATA_W.

## Test plan
- Legal traffic: header len = 3 plus 3 body flits, then header len = 0, all single-cycle hs. Required: pkt_cnt = 2, flit_cnt = 5, err_bits = 0, in_pkt low after last flit.
- Over-length: header len = MAX_BODY + 1, then a legal len = 0 header. Required: err_bits = 4'b0001, first_err = 4'b0001, pkt_cnt = 1.
- Stall violations:
  - mon_val = 1, mon_rdy = 0 for 2 cycles, then val dropped. Required: VAL_DROP set.
  - Separately, data changed on the 2nd stalled cycle. Required: DATA_UNSTABLE set, first_err = 4'b0100.
- DST mismatch with CHECK_DST = 1: header dst = EXP_DST + 1, len = 2, plus 2 body flits. Required: err_bits = 4'b1000, pkt_cnt = 1.
- Clear and reset: clear pulsed in the same cycle as a LEN_OVER header. Required: errors and counters 0 next cycle. Then rst_n pulsed low in BODY. Required: next hs is parsed as a header.
- Saturation with CNT_W = 4: 20 header-only packets. Required: pkt_cnt = flit_cnt = 15.
